// File: rtl/emergency_pkg.sv
// Shared types and defaults for the elevator emergency responder.
// The state encoding is the value driven on state_code.
package emergency_pkg;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_OVERWEIGHT    = 3'd1,
        ST_SOS_ALERT     = 3'd2,
        ST_SOS_ESCALATED = 3'd3,
        ST_RECOVERY      = 3'd4
    } state_t;

    localparam int BLINK_HALF_DEF      = 4;
    localparam int ACK_TIMEOUT_DEF     = 20;
    localparam int RECOVERY_CYCLES_DEF = 8;

    function automatic logic is_sos(input state_t s);
        return (s == ST_SOS_ALERT) || (s == ST_SOS_ESCALATED);
    endfunction

endpackage

// File: rtl/emergency_responder_if.sv
// Status inputs and actuator/alarm outputs of the emergency responder.
// event_count exists only when EMERGENCY_EVENT_COUNT_EN is defined.
interface emergency_responder_if
    import emergency_pkg::*;
;
    logic                       sos_mode;
    logic                       weight_limit_exceeded;
    logic                       operator_ack;
    logic                       motor_inhibit;
    logic                       door_hold_open;
    logic                       buzzer;
    logic                       sos_request;
    logic                       sos_escalate;
    logic [$bits(state_t)-1:0]  state_code;
`ifdef EMERGENCY_EVENT_COUNT_EN
    logic [7:0]                 event_count;
`endif

    modport master (
        output sos_mode, weight_limit_exceeded, operator_ack,
        input  motor_inhibit, door_hold_open, buzzer, sos_request, sos_escalate, state_code
`ifdef EMERGENCY_EVENT_COUNT_EN
        , input event_count
`endif
    );

    modport slave (
        input  sos_mode, weight_limit_exceeded, operator_ack,
        output motor_inhibit, door_hold_open, buzzer, sos_request, sos_escalate, state_code
`ifdef EMERGENCY_EVENT_COUNT_EN
        , output event_count
`endif
    );

endinterface

// File: rtl/emergency_buzzer_gen.sv
// Square-wave blink for the SOS buzzer: restart loads a high phase,
// enable advances the half-period counter.
module emergency_buzzer_gen
    import emergency_pkg::*;
#(
    parameter int BLINK_HALF = BLINK_HALF_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic blink
);

    localparam int            CW   = $clog2(BLINK_HALF + 1);
    localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

    logic [CW-1:0] cnt_reg;
    logic          blink_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg   <= '0;
            blink_reg <= 1'b0;
        end else if (restart) begin
            cnt_reg   <= '0;
            blink_reg <= 1'b1;
        end else if (enable) begin
            if (cnt_reg == LAST) begin
                cnt_reg   <= '0;
                blink_reg <= ~blink_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign blink = blink_reg;

endmodule

// File: rtl/emergency_responder.sv
// Elevator emergency FSM: overweight lockout, SOS alert/escalation, recovery hold.
// Define EMERGENCY_EVENT_COUNT_EN to add the saturating event_count output.
module emergency_responder
    import emergency_pkg::*;
#(
    parameter int BLINK_HALF      = BLINK_HALF_DEF,
    parameter int ACK_TIMEOUT     = ACK_TIMEOUT_DEF,
    parameter int RECOVERY_CYCLES = RECOVERY_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    emergency_responder_if.slave  bus
);

    localparam int            TW       = $clog2(ACK_TIMEOUT + 1);
    localparam int            RW       = $clog2(RECOVERY_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(ACK_TIMEOUT);
    localparam logic [RW-1:0] REC_LAST = RW'(RECOVERY_CYCLES - 1);
    localparam logic [RW-1:0] REC_MAX  = RW'(RECOVERY_CYCLES);

    state_t        state_reg, state_next;
    logic          acked_reg, acked_next;
    logic [TW-1:0] to_cnt_reg;
    logic [RW-1:0] rec_cnt_reg;
    logic          sa_entry, sa_stay, rec_entry, blink;
`ifdef EMERGENCY_EVENT_COUNT_EN
    logic [7:0]    event_count_reg;
    logic          ev_entry;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.sos_mode)                   state_next = ST_SOS_ALERT;
                else if (bus.weight_limit_exceeded) state_next = ST_OVERWEIGHT;
            end
            ST_OVERWEIGHT: begin
                if (bus.sos_mode)                    state_next = ST_SOS_ALERT;
                else if (!bus.weight_limit_exceeded) state_next = ST_RECOVERY;
            end
            ST_SOS_ALERT: begin
                // An ack arriving on the timeout cycle suppresses escalation.
                if (!bus.sos_mode && acked_reg)
                    state_next = ST_RECOVERY;
                else if (to_cnt_reg == TO_LAST && !acked_reg && !bus.operator_ack)
                    state_next = ST_SOS_ESCALATED;
            end
            ST_SOS_ESCALATED: begin
                if (!bus.sos_mode && acked_reg) state_next = ST_RECOVERY;
            end
            ST_RECOVERY: begin
                if (bus.sos_mode)                   state_next = ST_SOS_ALERT;
                else if (bus.weight_limit_exceeded) state_next = ST_OVERWEIGHT;
                else if (rec_cnt_reg == REC_LAST)   state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign sa_entry  = (state_next == ST_SOS_ALERT) && (state_reg != ST_SOS_ALERT);
    assign sa_stay   = (state_next == ST_SOS_ALERT) && (state_reg == ST_SOS_ALERT);
    assign rec_entry = (state_next == ST_RECOVERY)  && (state_reg != ST_RECOVERY);
`ifdef EMERGENCY_EVENT_COUNT_EN
    assign ev_entry  = ((state_next == ST_OVERWEIGHT) || (state_next == ST_SOS_ALERT))
                       && (state_next != state_reg);
`endif

    always_comb begin
        acked_next = acked_reg;
        if (sa_entry && !is_sos(state_reg))
            acked_next = 1'b0;
        else if (is_sos(state_reg) && bus.operator_ack)
            acked_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            acked_reg   <= 1'b0;
            to_cnt_reg  <= '0;
            rec_cnt_reg <= '0;
`ifdef EMERGENCY_EVENT_COUNT_EN
            event_count_reg <= 8'd0;
`endif
        end else begin
            state_reg <= state_next;
            acked_reg <= acked_next;
            if (sa_entry)
                to_cnt_reg <= '0;
            else if (state_reg == ST_SOS_ALERT && to_cnt_reg != TO_MAX)
                to_cnt_reg <= to_cnt_reg + 1'b1;
            if (rec_entry)
                rec_cnt_reg <= '0;
            else if (state_reg == ST_RECOVERY && rec_cnt_reg != REC_MAX)
                rec_cnt_reg <= rec_cnt_reg + 1'b1;
`ifdef EMERGENCY_EVENT_COUNT_EN
            if (ev_entry && event_count_reg != 8'hFF)
                event_count_reg <= event_count_reg + 8'd1;
`endif
        end
    end

    emergency_buzzer_gen #(
        .BLINK_HALF (BLINK_HALF)
    ) u_buzzer_gen (
        .clk     (clk),
        .reset   (reset),
        .enable  (sa_stay),
        .restart (sa_entry),
        .blink   (blink)
    );

    // Outputs are a pure decode of registered state, so they lag inputs by one edge.
    always_comb begin
        bus.motor_inhibit  = 1'b0;
        bus.door_hold_open = 1'b0;
        bus.buzzer         = 1'b0;
        bus.sos_request    = 1'b0;
        bus.sos_escalate   = 1'b0;
        case (state_reg)
            ST_OVERWEIGHT: begin
                bus.motor_inhibit  = 1'b1;
                bus.door_hold_open = 1'b1;
                bus.buzzer         = 1'b1;
            end
            ST_SOS_ALERT: begin
                bus.motor_inhibit = 1'b1;
                bus.sos_request   = !acked_reg;
                bus.buzzer        = blink && !acked_reg;
            end
            ST_SOS_ESCALATED: begin
                bus.motor_inhibit = 1'b1;
                bus.sos_escalate  = 1'b1;
                bus.sos_request   = !acked_reg;
                bus.buzzer        = !acked_reg;
            end
            ST_RECOVERY: begin
                bus.motor_inhibit = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.state_code = state_reg;
`ifdef EMERGENCY_EVENT_COUNT_EN
    assign bus.event_count = event_count_reg;
`endif

endmodule

// File: tb/tb_emergency_responder.sv
// Directed bench for emergency_responder (default parameters); event_count
// checks are compiled in when EMERGENCY_EVENT_COUNT_EN is defined.
module tb_emergency_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    emergency_responder_if bus ();

    emergency_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Packed expectation: {state_code, motor_inhibit, door_hold_open, buzzer, sos_request, sos_escalate}
    localparam logic [7:0] E_IDLE   = {3'd0, 5'b00000};
    localparam logic [7:0] E_OW     = {3'd1, 5'b11100};
    localparam logic [7:0] E_SA_ON  = {3'd2, 5'b10110};
    localparam logic [7:0] E_SA_OFF = {3'd2, 5'b10010};
    localparam logic [7:0] E_SA_ACK = {3'd2, 5'b10000};
    localparam logic [7:0] E_SE     = {3'd3, 5'b10111};
    localparam logic [7:0] E_SE_ACK = {3'd3, 5'b10001};
    localparam logic [7:0] E_REC    = {3'd4, 5'b10000};

    typedef struct {
        string      name;
        logic       rst;
        logic       sos;
        logic       wle;
        logic       ack;
        int         reps;
        logic [7:0] exp;
    } row_t;

    row_t vec[$];

    function automatic logic [7:0] outs();
        return {bus.state_code, bus.motor_inhibit, bus.door_hold_open,
                bus.buzzer, bus.sos_request, bus.sos_escalate};
    endfunction

    task automatic drive(input logic r, input logic s, input logic w, input logic a);
        reset                     = r;
        bus.sos_mode              = s;
        bus.weight_limit_exceeded = w;
        bus.operator_ack          = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] got;
        got = outs();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got st=%0d mi/dho/buz/req/esc=%b, want st=%0d mi/dho/buz/req/esc=%b",
                     name, got[7:5], got[4:0], exp[7:5], exp[4:0]);
        end
    endtask

`ifdef EMERGENCY_EVENT_COUNT_EN
    task automatic check_ec(input string name, input logic [7:0] exp);
        checks++;
        if (bus.event_count !== exp) begin
            failures++;
            $display("FAIL %s: event_count got %0d want %0d", name, bus.event_count, exp);
        end
    endtask
`endif

    function automatic void add(input string n, input logic r, input logic s, input logic w,
                                input logic a, input int reps, input logic [7:0] e);
        row_t t;
        t.name = n; t.rst = r; t.sos = s; t.wle = w; t.ack = a; t.reps = reps; t.exp = e;
        vec.push_back(t);
    endfunction

    initial begin
        reset = 1'b1;
        bus.sos_mode = 1'b0;
        bus.weight_limit_exceeded = 1'b0;
        bus.operator_ack = 1'b0;

        //   name            rst sos wle ack reps expected
        add("reset_idle",    1, 0, 0, 0,  2, E_IDLE);
        add("ow_hold",       0, 0, 1, 0, 10, E_OW);
        add("ow_recovery",   0, 0, 0, 0,  8, E_REC);
        add("rec_to_idle",   0, 0, 0, 0,  2, E_IDLE);
        add("ow_again",      0, 0, 1, 0,  1, E_OW);
        add("rec_partial",   0, 0, 0, 0,  3, E_REC);
        add("rec_to_ow",     0, 0, 1, 0,  1, E_OW);
        add("rec_restart",   0, 0, 0, 0,  8, E_REC);
        add("rec_done",      0, 0, 0, 0,  1, E_IDLE);
        add("ow_pre_reset",  0, 0, 1, 0,  1, E_OW);
        add("reset_in_ow",   1, 0, 1, 0,  1, E_IDLE);
        add("ow_post_reset", 0, 0, 1, 0,  2, E_OW);
        add("ow_to_sos",     0, 1, 1, 0,  1, E_SA_ON);
        add("blink_hi_a",    0, 1, 1, 0,  3, E_SA_ON);
        add("blink_lo_a",    0, 1, 1, 0,  4, E_SA_OFF);
        add("blink_hi_b",    0, 1, 1, 0,  4, E_SA_ON);
        add("blink_lo_b",    0, 1, 1, 0,  4, E_SA_OFF);
        add("blink_hi_c",    0, 1, 1, 0,  4, E_SA_ON);
        add("escalated",     0, 1, 1, 0,  3, E_SE);
        add("se_unacked",    0, 0, 0, 0,  2, E_SE);
        add("se_acked",      0, 0, 0, 1,  1, E_SE_ACK);
        add("se_recovery",   0, 0, 0, 0,  8, E_REC);
        add("se_idle",       0, 0, 0, 0,  1, E_IDLE);

        foreach (vec[i]) begin
            for (int k = 0; k < vec[i].reps; k++) begin
                drive(vec[i].rst, vec[i].sos, vec[i].wle, vec[i].ack);
                check(vec[i].name, vec[i].exp);
            end
            $display("row %0d %s reps=%0d st=%0d", i, vec[i].name, vec[i].reps, vec[i].exp[7:5]);
        end

        // Ack pulse in cycle 5, SOS released in cycle 12.
        drive(0, 1, 0, 0);
        check("ackseq_c0", E_SA_ON);
        for (int k = 0; k < 12; k++) begin
            drive(0, 1, 0, (k == 5));
            if (k + 1 <= 3)      check("ackseq_on", E_SA_ON);
            else if (k + 1 <= 5) check("ackseq_off", E_SA_OFF);
            else                 check("ackseq_acked", E_SA_ACK);
        end
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 0);
            check("ackseq_rec", E_REC);
        end
        drive(0, 0, 0, 0);
        check("ackseq_idle", E_IDLE);
        $display("seq ack_pulse done");

        // Ack on the timeout cycle beats escalation; SOS wins over overweight from IDLE.
        drive(0, 1, 1, 0);
        check("to_entry", E_SA_ON);
        for (int c = 0; c < 19; c++) begin
            drive(0, 1, 0, 0);
            check("to_blink", (((c + 1) / 4) % 2 == 0) ? E_SA_ON : E_SA_OFF);
        end
        drive(0, 1, 0, 1);
        check("to_ack_wins", E_SA_ACK);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 0);
            check("to_no_escal", E_SA_ACK);
        end
        drive(0, 0, 0, 0);
        check("to_rec", E_REC);
        drive(0, 0, 0, 0);
        check("to_rec2", E_REC);
        drive(1, 0, 0, 0);
        check("reset_in_rec", E_IDLE);
        drive(0, 0, 0, 0);
        check("post_reset_idle", E_IDLE);
        $display("seq ack_at_timeout done");

        // Reset while escalated with SOS still asserted.
        drive(0, 1, 0, 0);
        for (int k = 0; k < 20; k++) drive(0, 1, 0, 0);
        check("esc_reach", E_SE);
`ifdef EMERGENCY_EVENT_COUNT_EN
        check_ec("ec_one_entry", 8'd1);
`endif
        drive(1, 1, 0, 0);
        check("esc_reset", E_IDLE);
`ifdef EMERGENCY_EVENT_COUNT_EN
        check_ec("ec_reset", 8'd0);
`endif
        drive(0, 1, 0, 0);
        check("esc_resume", E_SA_ON);
`ifdef EMERGENCY_EVENT_COUNT_EN
        check_ec("ec_resume", 8'd1);
`endif
        $display("seq reset_escalated done");

`ifdef EMERGENCY_EVENT_COUNT_EN
        drive(1, 0, 0, 0);
        for (int i = 1; i <= 300; i++) begin
            drive(0, 0, 1, 0);
            drive(0, 0, 0, 0);
            if (i == 10)  check_ec("ec_10", 8'd10);
            if (i == 255) check_ec("ec_255", 8'd255);
        end
        check_ec("ec_saturated", 8'd255);
        check("ec_final_state", E_REC);
        $display("seq event_count_saturation done");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/emergency_responder.md
EMERGENCY_RESPONDER -- requirements
Module: emergency_responder

Interface
REQ-001 Parameter BLINK_HALF, default 4: SOS buzzer half-period in clk cycles, >=1.
REQ-002 Parameter ACK_TIMEOUT, default 20: cycles in SOS_ALERT without ack before escalation, >=1.
REQ-003 Parameter RECOVERY_CYCLES, default 8: motor-inhibit hold time after an emergency clears, >=1.
REQ-004 clk  input  1  single system clock; all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sos_mode  input  1  SOS active level from sos handler, already synchronous to clk.
REQ-007 weight_limit_exceeded  input  1  overweight level from weight control, already synchronous.
REQ-008 operator_ack  input  1  one-cycle-or-longer operator acknowledge.
REQ-009 motor_inhibit  output  1  forbids cabin motion.
REQ-010 door_hold_open  output  1  forces doors open.
REQ-011 buzzer  output  1  cabin alarm drive.
REQ-012 sos_request  output  1  alarm request to operator panel.
REQ-013 sos_escalate  output  1  unacknowledged-SOS escalation.
REQ-014 state_code  output  3  current state encoding.
REQ-015 event_count  output  8  emergency entry counter; present only with EMERGENCY_EVENT_COUNT_EN.

Function
REQ-016 FSM states, encodings: IDLE=0, OVERWEIGHT=1, SOS_ALERT=2, SOS_ESCALATED=3, RECOVERY=4; state_code equals the state register.
REQ-017 All outputs are registered or decoded from registered state; an input change is reflected on outputs one cycle after the sampling edge.
REQ-018 IDLE: sos_mode=1 -> SOS_ALERT; else weight_limit_exceeded=1 -> OVERWEIGHT; all outputs 0.
REQ-019 OVERWEIGHT: motor_inhibit=1, door_hold_open=1, buzzer=1 steady; sos_mode=1 -> SOS_ALERT (SOS has priority); else weight_limit_exceeded=0 -> RECOVERY.
REQ-020 SOS_ALERT: motor_inhibit=1, sos_request=1, buzzer toggles every BLINK_HALF cycles starting at 1 on entry; timeout counter clears on entry and increments each cycle.
REQ-021 An acked flag clears on SOS_ALERT entry from a non-SOS state and sets when operator_ack=1 in SOS_ALERT or SOS_ESCALATED; while acked, buzzer=0 and sos_request=0.
REQ-022 SOS_ALERT: counter reaching ACK_TIMEOUT with acked=0 -> SOS_ESCALATED; ack on the same cycle as timeout wins (no escalation).
REQ-023 SOS_ESCALATED: motor_inhibit=1, sos_escalate=1, sos_request=1 and buzzer=1 steady until acked.
REQ-024 Either SOS state exits to RECOVERY only when sos_mode=0 and acked=1; sos_mode dropping unacked holds the state.
REQ-025 RECOVERY: motor_inhibit=1 for RECOVERY_CYCLES cycles, then IDLE; sos_mode=1 -> SOS_ALERT; else weight_limit_exceeded=1 -> OVERWEIGHT; counter restarts on every entry.
REQ-026 Counters are $clog2(max+1) wide and never wrap; the blink counter resets on every SOS_ALERT entry.
REQ-027 Encodings 5..7 are illegal and transition to IDLE next cycle.

Reset
REQ-028 reset=1 at a rising edge forces IDLE, all counters and acked to 0, all outputs 0, mid-operation included; reset has priority over every input.

Configuration
REQ-029 With EMERGENCY_EVENT_COUNT_EN defined, event_count increments on each entry into OVERWEIGHT or SOS_ALERT from another state, saturates at 255, and resets to 0.
REQ-030 Without EMERGENCY_EVENT_COUNT_EN, the event_count port and its logic are absent; all other behaviour is identical.

Structure
REQ-031 Package emergency_pkg holds the state typedef/encodings and the default values of BLINK_HALF, ACK_TIMEOUT and RECOVERY_CYCLES.
REQ-032 Sub-module emergency_buzzer_gen (enable, restart, BLINK_HALF parameter -> toggling output) produces the SOS blink; the FSM is instantiated in emergency_responder.

Verification (defaults)
REQ-033 weight_limit_exceeded=1 for 10 cycles, then 0 -> OVERWEIGHT one cycle later with motor_inhibit=door_hold_open=buzzer=1; after release, RECOVERY for 8 cycles, then IDLE with all outputs 0.
REQ-034 sos_mode=1 with no ack -> SOS_ALERT, buzzer period 8 cycles, sos_request=1; after 20 cycles, SOS_ESCALATED with sos_escalate=1 and buzzer steady.
REQ-035 SOS held, operator_ack pulse at cycle 5, sos_mode=0 at cycle 12 -> buzzer and sos_request 0 from cycle 6, no escalation, RECOVERY then IDLE after 8 cycles.
REQ-036 sos_mode=1 while in OVERWEIGHT and weight_limit_exceeded stays 1 -> SOS_ALERT next cycle; door_hold_open drops to 0.
REQ-037 reset=1 for one cycle in SOS_ESCALATED -> IDLE, all outputs 0 (event_count 0 when enabled); sos_mode still 1 -> SOS_ALERT the cycle after reset deasserts.
REQ-038 With EMERGENCY_EVENT_COUNT_EN, 300 alternating overweight episodes -> event_count saturates at 255.
